integer_multiplier_radix: RTL and testbench

// Iterative signed/unsigned integer multiplier for the ALU_simple execution path.
// It retires BITS_PER_CYCLE multiplier bits per clock, so a designer trades area for latency.

---
 rtl/integer_multiplier_radix.sv | 168 ++++++++++++++++
 tb/tb_integer_multiplier_radix.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/integer_multiplier_radix.sv
// Iterative radix-2^B integer multiplier with per-operand signedness.
// Operands in via valid/ack handshake; product held until consumer acks.
module integer_multiplier_radix #(
    parameter int OPERAND_WIDTH_IN_BITS = 64,
    parameter int PRODUCT_WIDTH_IN_BITS = 128,
    parameter int BITS_PER_CYCLE        = 2
) (
    input  logic                             clk_in,
    input  logic                             reset_in,
    input  logic                             multiplicand_valid_in,
    input  logic                             multiplicand_sign_in,
    input  logic [OPERAND_WIDTH_IN_BITS-1:0] multiplicand_in,
    input  logic                             multiplier_valid_in,
    input  logic                             multiplier_sign_in,
    input  logic [OPERAND_WIDTH_IN_BITS-1:0] multiplier_in,
    output logic                             issue_ack_out,
    output logic                             product_valid_out,
    output logic                             product_sign_out,
    output logic [PRODUCT_WIDTH_IN_BITS-1:0] product_out,
    input  logic                             issue_ack_in,
    output logic                             multiply_exception_out
);

    localparam int W  = OPERAND_WIDTH_IN_BITS;
    localparam int B  = BITS_PER_CYCLE;
    localparam int N  = W / B;
    localparam int SW = $clog2(N + 1);

    localparam logic [SW-1:0]    LAST     = SW'(N - 1);
    localparam logic [SW-1:0]    STEP_ONE = SW'(1);
    localparam logic [2*W-1:0]   ONE_2W   = (2*W)'(1);
    localparam logic [W-1:0]     ONE_W    = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] acc_q;
    logic [SW-1:0]  step_q;
    logic           rsign_q;
    logic           zero_q;

    logic           both_valid;
    logic           one_valid;
    logic           neg_a;
    logic           neg_b;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;

    logic [B-1:0]   digit;
    logic [W+B-1:0] pp;
    logic [W+B-1:0] sum;
    logic [2*W-1:0] acc_d;
    logic [2*W-1:0] prod_d;

    assign both_valid = multiplicand_valid_in & multiplier_valid_in;
    assign one_valid  = multiplicand_valid_in ^ multiplier_valid_in;

    // Magnitudes fit W unsigned bits, including the most negative value.
    always_comb begin
        neg_a = multiplicand_sign_in & multiplicand_in[W-1];
        neg_b = multiplier_sign_in & multiplier_in[W-1];
        a_mag = neg_a ? (~multiplicand_in + ONE_W) : multiplicand_in;
        b_mag = neg_b ? (~multiplier_in + ONE_W) : multiplier_in;
    end

    // Shift-right accumulator: upper half gathers partial sums while the
    // low half drains the multiplier B bits at a time.
    always_comb begin
        digit  = acc_q[B-1:0];
        pp     = {{B{1'b0}}, mcand_q} * {{W{1'b0}}, digit};
        sum    = {{B{1'b0}}, acc_q[2*W-1:W]} + pp;
        acc_d  = {sum, acc_q[W-1:B]};
        prod_d = rsign_q ? (~acc_d + ONE_2W) : acc_d;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (both_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (zero_q || step_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (issue_ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mcand_q                <= '0;
            acc_q                  <= '0;
            step_q                 <= '0;
            rsign_q                <= 1'b0;
            zero_q                 <= 1'b0;
            issue_ack_out          <= 1'b0;
            multiply_exception_out <= 1'b0;
            product_valid_out      <= 1'b0;
            product_sign_out       <= 1'b0;
            product_out            <= '0;
        end else begin
            issue_ack_out          <= 1'b0;
            multiply_exception_out <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (both_valid) begin
                        mcand_q       <= a_mag;
                        acc_q         <= {{W{1'b0}}, b_mag};
                        step_q        <= '0;
                        rsign_q       <= neg_a ^ neg_b;
                        zero_q        <= (a_mag == '0) || (b_mag == '0);
                        issue_ack_out <= 1'b1;
                    end else if (one_valid) begin
                        multiply_exception_out <= 1'b1;
                    end
                end
                BUSY: begin
                    if (zero_q) begin
                        product_valid_out <= 1'b1;
                        product_sign_out  <= 1'b0;
                        product_out       <= '0;
                    end else begin
                        acc_q  <= acc_d;
                        step_q <= step_q + STEP_ONE;
                        if (step_q == LAST) begin
                            product_valid_out <= 1'b1;
                            product_sign_out  <= rsign_q;
                            product_out       <= prod_d;
                        end
                    end
                end
                DONE: begin
                    if (issue_ack_in) begin
                        product_valid_out <= 1'b0;
                        product_sign_out  <= 1'b0;
                        product_out       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_integer_multiplier_radix.sv
// Directed bench for integer_multiplier_radix (W=64, B=2).
// Table of vectors plus backpressure, reset and exception sequences.
module tb_integer_multiplier_radix;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         multiplicand_valid_in;
    logic         multiplicand_sign_in;
    logic [63:0]  multiplicand_in;
    logic         multiplier_valid_in;
    logic         multiplier_sign_in;
    logic [63:0]  multiplier_in;
    logic         issue_ack_out;
    logic         product_valid_out;
    logic         product_sign_out;
    logic [127:0] product_out;
    logic         issue_ack_in;
    logic         multiply_exception_out;

    int total  = 0;
    int passed = 0;

    integer_multiplier_radix #(
        .OPERAND_WIDTH_IN_BITS(64),
        .PRODUCT_WIDTH_IN_BITS(128),
        .BITS_PER_CYCLE(2)
    ) dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .multiplicand_valid_in (multiplicand_valid_in),
        .multiplicand_sign_in  (multiplicand_sign_in),
        .multiplicand_in       (multiplicand_in),
        .multiplier_valid_in   (multiplier_valid_in),
        .multiplier_sign_in    (multiplier_sign_in),
        .multiplier_in         (multiplier_in),
        .issue_ack_out         (issue_ack_out),
        .product_valid_out     (product_valid_out),
        .product_sign_out      (product_sign_out),
        .product_out           (product_out),
        .issue_ack_in          (issue_ack_in),
        .multiply_exception_out(multiply_exception_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [63:0]  a;
        logic         sa;
        logic [63:0]  b;
        logic         sb;
        logic [127:0] p;
        logic         s;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] a, input logic sa,
                         input logic [63:0] b, input logic sb);
        multiplicand_valid_in = 1'b1;
        multiplicand_sign_in  = sa;
        multiplicand_in       = a;
        multiplier_valid_in   = 1'b1;
        multiplier_sign_in    = sb;
        multiplier_in         = b;
    endtask

    task automatic scramble();
        multiplicand_valid_in = 1'b0;
        multiplier_valid_in   = 1'b0;
        multiplicand_in       = {$urandom, $urandom};
        multiplier_in         = {$urandom, $urandom};
        multiplicand_sign_in  = 1'($urandom);
        multiplier_sign_in    = 1'($urandom);
    endtask

    // Called at a negedge with state IDLE and ack edge already passed.
    task automatic wait_product(input string tag, input int exp_lat);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk_in);
            n++;
            @(negedge clk_in);
            got = product_valid_out;
        end
        chk({tag, " latency"}, 128'(n), 128'(exp_lat));
    endtask

    task automatic consume(input string tag);
        issue_ack_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        issue_ack_in = 1'b0;
        chk({tag, " valid cleared"}, 128'(product_valid_out), 128'(0));
        chk({tag, " product cleared"}, product_out, 128'(0));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(v.a, v.sa, v.b, v.sb);
        @(posedge clk_in);
        @(negedge clk_in);
        scramble();
        chk({tag, " ack"}, 128'(issue_ack_out), 128'(1));
        wait_product(tag, v.lat);
        chk({tag, " product"}, product_out, v.p);
        chk({tag, " sign"}, 128'(product_sign_out), 128'(v.s));
        consume(tag);
    endtask

    initial begin
        logic seen;
        logic [127:0] held;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0, 32};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd5, 1'b1,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB, 1'b1, 32};
        vecs[2] = '{64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b1,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 32};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 1'b1, 32};
        vecs[4] = '{64'd0, 1'b0, 64'h1234, 1'b0, 128'd0, 1'b0, 1};
        vecs[5] = '{64'd3, 1'b0, 64'd7, 1'b0, 128'd21, 1'b0, 32};
        vecs[6] = '{64'h8000_0000_0000_0000, 1'b1, 64'd1, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b1, 32};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 128'd0, 1'b0, 1};
        vecs[8] = '{64'h0000_0001_0000_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 32};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1,
                    128'd6, 1'b0, 32};

        reset_in     = 1'b1;
        issue_ack_in = 1'b0;
        scramble();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset valid", 128'(product_valid_out), 128'(0));
        chk("reset product", product_out, 128'(0));
        chk("reset ack", 128'(issue_ack_out), 128'(0));
        chk("reset exc", 128'(multiply_exception_out), 128'(0));
        reset_in = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: product held while new operands wait.
        drive(64'd3, 1'b0, 64'd7, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        scramble();
        wait_product("bp first", 32);
        chk("bp first product", product_out, 128'd21);
        held = product_out;
        drive(64'd11, 1'b0, 64'd13, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            seen = seen | issue_ack_out | (product_out != held)
                 | !product_valid_out;
        end
        chk("bp held stable", 128'(seen), 128'(0));
        issue_ack_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        issue_ack_in = 1'b0;
        chk("bp no capture on ack edge", 128'(issue_ack_out), 128'(0));
        chk("bp valid dropped", 128'(product_valid_out), 128'(0));
        @(posedge clk_in);
        @(negedge clk_in);
        scramble();
        chk("bp next capture", 128'(issue_ack_out), 128'(1));
        wait_product("bp second", 32);
        chk("bp second product", product_out, 128'd143);
        consume("bp second");

        // Reset partway through the iteration.
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        scramble();
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        chk("midreset valid", 128'(product_valid_out), 128'(0));
        chk("midreset product", product_out, 128'(0));
        chk("midreset sign", 128'(product_sign_out), 128'(0));
        chk("midreset ack", 128'(issue_ack_out), 128'(0));
        @(negedge clk_in);
        reset_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            seen = seen | product_valid_out;
        end
        chk("midreset no product", 128'(seen), 128'(0));

        // Lone multiplier valid raises an exception, not an ack.
        multiplier_valid_in = 1'b1;
        multiplier_in       = 64'd9;
        @(posedge clk_in);
        @(negedge clk_in);
        multiplier_valid_in = 1'b0;
        chk("exc pulse", 128'(multiply_exception_out), 128'(1));
        chk("exc no ack", 128'(issue_ack_out), 128'(0));
        @(posedge clk_in);
        @(negedge clk_in);
        chk("exc one cycle", 128'(multiply_exception_out), 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            seen = seen | issue_ack_out | product_valid_out;
        end
        chk("exc nothing started", 128'(seen), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
